// File: rtl/frame_pkg.sv
// Shared types and constants for the MAC RX frame receiver.
package frame_pkg;

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_IDLE        = 3'd1,
        ST_MAC_DST     = 3'd2,
        ST_MAC_SRC     = 3'd3,
        ST_ETH_TYPE    = 3'd4,
        ST_DATA        = 3'd5,
        ST_WAIT_STATUS = 3'd6,
        ST_DROP        = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        DR_NONE      = 3'd0,
        DR_RUNT      = 3'd1,
        DR_ADDR      = 3'd2,
        DR_BAD       = 3'd3,
        DR_LEN       = 3'd4,
        DR_NO_STATUS = 3'd5
    } drop_reason_t;

    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/rx_hdr_capture.sv
// Shifts header bytes into dst/src/type shadow registers by byte index;
// the visible header registers only update on the load strobe.
module rx_hdr_capture (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_byte_en,
    input  logic [3:0]  i_byte_idx,
    input  logic [7:0]  i_data,
    input  logic        i_load,
    output logic [47:0] o_dst_next,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [15:0] o_eth_type
);

    logic [47:0] r_dst_sh;
    logic [47:0] r_src_sh;
    logic [15:0] r_type_sh;
    logic [47:0] r_dst_mac;
    logic [47:0] r_src_mac;
    logic [15:0] r_eth_type;

    // Address filter looks at the full destination including the byte arriving now.
    assign o_dst_next = {r_dst_sh[39:0], i_data};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dst_sh   <= '0;
            r_src_sh   <= '0;
            r_type_sh  <= '0;
            r_dst_mac  <= '0;
            r_src_mac  <= '0;
            r_eth_type <= '0;
        end else begin
            if (i_byte_en) begin
                if (i_byte_idx < 4'd6)
                    r_dst_sh <= o_dst_next;
                else if (i_byte_idx < 4'd12)
                    r_src_sh <= {r_src_sh[39:0], i_data};
                else if (i_byte_idx < 4'd14)
                    r_type_sh <= {r_type_sh[7:0], i_data};
            end
            if (i_load) begin
                r_dst_mac  <= r_dst_sh;
                r_src_mac  <= r_src_sh;
                r_eth_type <= r_type_sh;
            end
        end
    end

    assign o_dst_mac  = r_dst_mac;
    assign o_src_mac  = r_src_mac;
    assign o_eth_type = r_eth_type;

endmodule

// File: rtl/frame_receiver.sv
// MAC RX client: parses the Ethernet header, filters on destination MAC,
// and classifies each frame as received or dropped.
//
// state        | meaning
// RESET        | one cycle after reset release, MAC RX still disabled
// IDLE         | waiting for a dvld rising edge
// MAC_DST      | bytes 0-5, destination MAC
// MAC_SRC      | bytes 6-11, source MAC
// ETH_TYPE     | bytes 12-13, EtherType
// DATA         | payload bytes, counting
// WAIT_STATUS  | dvld fell, waiting for MAC good/bad pulse
// DROP         | discarding until dvld falls
module frame_receiver
    import frame_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC      = 48'h0012E228130E,
    parameter logic        PROMISC        = 1'b0,
    parameter int          MIN_FRAME      = 60,
    parameter int          MAX_FRAME      = 1514,
    parameter int          STATUS_TIMEOUT = 16
) (
    input  logic        rx_clk,
    input  logic        reset,
    output logic        conf_rx_en,
    output logic        conf_rx_jumbo_en,
    output logic        conf_rx_no_chk_crc,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_good_frame,
    input  logic        mac_rx_bad_frame,
    output logic [47:0] rx_dst_mac,
    output logic [47:0] rx_src_mac,
    output logic [15:0] rx_eth_type,
    output logic [10:0] rx_byte_count,
    output logic        frame_received,
    output logic        frame_dropped,
    output logic [2:0]  drop_reason,
    output logic [15:0] good_count,
    output logic [15:0] drop_count
);

    localparam logic [10:0] MIN_B    = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_B    = 11'(MAX_FRAME);
    localparam logic [7:0]  TMR_LOAD = 8'(STATUS_TIMEOUT - 1);

    state_t       r_state, w_next_state;
    drop_reason_t r_pend, w_pend_val, w_reason, r_drop_reason;
    logic         w_pend_set, w_drop, w_accept, w_resolve;
    logic         w_timer_load, w_timer_dec;
    logic         r_dvld_d, r_conf_rx_en;
    logic [10:0]  r_byte_cnt, r_rx_byte_count;
    logic [7:0]   r_timer;
    logic         r_frame_received, r_frame_dropped;
    logic [15:0]  r_good_count, r_drop_count;
    logic [47:0]  w_dst_next;
    logic         w_addr_ok, w_len_ok, w_status, w_cap_en, w_in_hdr;

    assign w_in_hdr  = (r_state == ST_MAC_DST) || (r_state == ST_MAC_SRC) ||
                       (r_state == ST_ETH_TYPE);
    assign w_cap_en  = mac_rx_dvld &&
                       (((r_state == ST_IDLE) && !r_dvld_d) || w_in_hdr);
    assign w_addr_ok = PROMISC || (w_dst_next == LOCAL_MAC) ||
                       (w_dst_next == BROADCAST_MAC);
    assign w_len_ok  = (r_byte_cnt >= MIN_B) && (r_byte_cnt <= MAX_B);
    assign w_status  = mac_rx_good_frame || mac_rx_bad_frame;

    rx_hdr_capture u_hdr (
        .i_clk      (rx_clk),
        .i_reset    (reset),
        .i_byte_en  (w_cap_en),
        .i_byte_idx (r_byte_cnt[3:0]),
        .i_data     (mac_rx_data),
        .i_load     (w_accept),
        .o_dst_next (w_dst_next),
        .o_dst_mac  (rx_dst_mac),
        .o_src_mac  (rx_src_mac),
        .o_eth_type (rx_eth_type)
    );

    always_ff @(posedge rx_clk) begin
        if (reset)
            r_state <= ST_RESET;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_drop       = 1'b0;
        w_reason     = DR_NONE;
        w_accept     = 1'b0;
        w_resolve    = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_val   = DR_NONE;
        w_timer_load = 1'b0;
        w_timer_dec  = 1'b0;
        case (r_state)
            ST_RESET: w_next_state = ST_IDLE;
            ST_IDLE: begin
                if (mac_rx_dvld && !r_dvld_d)
                    w_next_state = ST_MAC_DST;
            end
            ST_MAC_DST, ST_MAC_SRC, ST_ETH_TYPE: begin
                if (!mac_rx_dvld) begin
                    w_drop       = 1'b1;
                    w_reason     = DR_RUNT;
                    w_next_state = ST_IDLE;
                end else if ((r_state == ST_MAC_DST) && (r_byte_cnt == 11'd5)) begin
                    if (w_addr_ok) begin
                        w_next_state = ST_MAC_SRC;
                    end else begin
                        w_next_state = ST_DROP;
                        w_pend_set   = 1'b1;
                        w_pend_val   = DR_ADDR;
                    end
                end else if ((r_state == ST_MAC_SRC) && (r_byte_cnt == 11'd11)) begin
                    w_next_state = ST_ETH_TYPE;
                end else if ((r_state == ST_ETH_TYPE) && (r_byte_cnt == 11'd13)) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                // A status pulse coinciding with the dvld fall is honoured directly.
                if (!mac_rx_dvld) begin
                    if (w_status) begin
                        w_resolve    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_timer_load = 1'b1;
                        w_next_state = ST_WAIT_STATUS;
                    end
                end
            end
            ST_WAIT_STATUS: begin
                if (w_status) begin
                    w_resolve    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (mac_rx_dvld) begin
                    w_drop       = 1'b1;
                    w_reason     = DR_NO_STATUS;
                    w_pend_set   = 1'b1;
                    w_pend_val   = DR_NONE;
                    w_next_state = ST_DROP;
                end else if (r_timer == 8'd0) begin
                    w_drop       = 1'b1;
                    w_reason     = DR_NO_STATUS;
                    w_next_state = ST_IDLE;
                end else begin
                    w_timer_dec = 1'b1;
                end
            end
            ST_DROP: begin
                if (!mac_rx_dvld) begin
                    w_next_state = ST_IDLE;
                    if (r_pend != DR_NONE) begin
                        w_drop   = 1'b1;
                        w_reason = r_pend;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (w_resolve) begin
            if (mac_rx_bad_frame) begin
                w_drop   = 1'b1;
                w_reason = DR_BAD;
            end else if (w_len_ok) begin
                w_accept = 1'b1;
            end else begin
                w_drop   = 1'b1;
                w_reason = DR_LEN;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            r_dvld_d         <= 1'b0;
            r_conf_rx_en     <= 1'b0;
            r_byte_cnt       <= '0;
            r_timer          <= '0;
            r_pend           <= DR_NONE;
            r_frame_received <= 1'b0;
            r_frame_dropped  <= 1'b0;
            r_drop_reason    <= DR_NONE;
            r_rx_byte_count  <= '0;
            r_good_count     <= '0;
            r_drop_count     <= '0;
        end else begin
            r_dvld_d     <= mac_rx_dvld;
            r_conf_rx_en <= 1'b1;
            if (w_next_state == ST_IDLE)
                r_byte_cnt <= '0;
            else if (r_state == ST_IDLE)
                r_byte_cnt <= 11'd1;
            else if (mac_rx_dvld && (w_in_hdr || (r_state == ST_DATA)))
                r_byte_cnt <= sat_inc(r_byte_cnt);
            if (w_timer_load)
                r_timer <= TMR_LOAD;
            else if (w_timer_dec)
                r_timer <= r_timer - 8'd1;
            if (w_pend_set)
                r_pend <= w_pend_val;
            r_frame_received <= w_accept;
            r_frame_dropped  <= w_drop;
            r_drop_reason    <= w_drop ? w_reason : DR_NONE;
            if (w_accept) begin
                r_rx_byte_count <= r_byte_cnt;
                r_good_count    <= r_good_count + 16'd1;
            end
            if (w_drop)
                r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign conf_rx_en         = r_conf_rx_en;
    assign conf_rx_jumbo_en   = 1'b0;
    assign conf_rx_no_chk_crc = 1'b0;
    assign rx_byte_count      = r_rx_byte_count;
    assign frame_received     = r_frame_received;
    assign frame_dropped      = r_frame_dropped;
    assign drop_reason        = r_drop_reason;
    assign good_count         = r_good_count;
    assign drop_count         = r_drop_count;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: a filtering instance and a promiscuous one share stimulus.
module tb_frame_receiver;
    import frame_pkg::*;

    localparam logic [47:0] LOCAL   = 48'h0012E228130E;
    localparam logic [47:0] SRC_MAC = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] OTHER   = 48'h001122334455;

    logic        rx_clk = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  mac_rx_data = '0;
    logic        mac_rx_dvld = 1'b0;
    logic        mac_rx_good_frame = 1'b0;
    logic        mac_rx_bad_frame  = 1'b0;

    logic        conf_rx_en, conf_rx_jumbo_en, conf_rx_no_chk_crc;
    logic [47:0] rx_dst_mac, rx_src_mac;
    logic [15:0] rx_eth_type, good_count, drop_count;
    logic [10:0] rx_byte_count;
    logic        frame_received, frame_dropped;
    logic [2:0]  drop_reason;

    logic        p_conf_rx_en, p_conf_rx_jumbo_en, p_conf_rx_no_chk_crc;
    logic [47:0] p_rx_dst_mac, p_rx_src_mac;
    logic [15:0] p_rx_eth_type, p_good_count, p_drop_count;
    logic [10:0] p_rx_byte_count;
    logic        p_frame_received, p_frame_dropped;
    logic [2:0]  p_drop_reason;

    int n_pass = 0;
    int n_total = 0;
    int rcv_n = 0, drop_n = 0, both_n = 0;
    int p_rcv_n = 0;
    logic [2:0] last_reason = '0;
    int rcv_before, drop_before;

    always #5 rx_clk = ~rx_clk;

    frame_receiver #(.PROMISC(1'b0)) dut (
        .rx_clk(rx_clk), .reset(reset),
        .conf_rx_en(conf_rx_en), .conf_rx_jumbo_en(conf_rx_jumbo_en),
        .conf_rx_no_chk_crc(conf_rx_no_chk_crc),
        .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
        .mac_rx_good_frame(mac_rx_good_frame), .mac_rx_bad_frame(mac_rx_bad_frame),
        .rx_dst_mac(rx_dst_mac), .rx_src_mac(rx_src_mac), .rx_eth_type(rx_eth_type),
        .rx_byte_count(rx_byte_count), .frame_received(frame_received),
        .frame_dropped(frame_dropped), .drop_reason(drop_reason),
        .good_count(good_count), .drop_count(drop_count)
    );

    frame_receiver #(.PROMISC(1'b1)) dut_p (
        .rx_clk(rx_clk), .reset(reset),
        .conf_rx_en(p_conf_rx_en), .conf_rx_jumbo_en(p_conf_rx_jumbo_en),
        .conf_rx_no_chk_crc(p_conf_rx_no_chk_crc),
        .mac_rx_data(mac_rx_data), .mac_rx_dvld(mac_rx_dvld),
        .mac_rx_good_frame(mac_rx_good_frame), .mac_rx_bad_frame(mac_rx_bad_frame),
        .rx_dst_mac(p_rx_dst_mac), .rx_src_mac(p_rx_src_mac), .rx_eth_type(p_rx_eth_type),
        .rx_byte_count(p_rx_byte_count), .frame_received(p_frame_received),
        .frame_dropped(p_frame_dropped), .drop_reason(p_drop_reason),
        .good_count(p_good_count), .drop_count(p_drop_count)
    );

    // Pulse monitor: outputs are stable at the falling edge.
    always @(negedge rx_clk) begin
        if (frame_received) rcv_n++;
        if (frame_dropped) begin
            drop_n++;
            last_reason = drop_reason;
        end
        if (frame_received && frame_dropped) both_n++;
        if (p_frame_received) p_rcv_n++;
    end

    task automatic tick();
        @(negedge rx_clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] fbyte(input logic [47:0] dst, input logic [15:0] et, input int i);
        logic [47:0] s;
        s = SRC_MAC;
        if (i < 6)       return dst[8*(5-i) +: 8];
        else if (i < 12) return s[8*(11-i) +: 8];
        else if (i == 12) return et[15:8];
        else if (i == 13) return et[7:0];
        else             return 8'(i);
    endfunction

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len);
        for (int i = 0; i < len; i++) begin
            mac_rx_dvld = 1'b1;
            mac_rx_data = fbyte(dst, et, i);
            tick();
        end
        mac_rx_dvld = 1'b0;
        mac_rx_data = '0;
    endtask

    // delay = cycles between the last data byte and the status pulse
    task automatic status(input logic good, input logic bad, input int delay);
        repeat (delay - 1) tick();
        mac_rx_good_frame = good;
        mac_rx_bad_frame  = bad;
        tick();
        mac_rx_good_frame = 1'b0;
        mac_rx_bad_frame  = 1'b0;
    endtask

    task automatic settle();
        repeat (25) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_conf_rx_en", conf_rx_en, 1'b0);
        check("rst_good_count", good_count, 16'd0);
        check("rst_dst_mac", rx_dst_mac, 48'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("conf_rx_en", conf_rx_en, 1'b1);
        check("conf_jumbo", {conf_rx_jumbo_en, conf_rx_no_chk_crc}, 2'b00);

        // 60-byte ARP broadcast, good status two cycles after the last byte
        send_frame(BROADCAST_MAC, ETH_TYPE_ARP, 60);
        status(1'b1, 1'b0, 2);
        settle();
        check("arp_rcv_pulses", rcv_n, 1);
        check("arp_eth_type", rx_eth_type, 16'h0806);
        check("arp_byte_count", rx_byte_count, 11'd60);
        check("arp_good_count", good_count, 16'd1);
        check("arp_dst", rx_dst_mac, 48'hFFFFFFFFFFFF);
        check("arp_src", rx_src_mac, 48'h0A0B0C0D0E0F);

        // foreign destination: dropped unless promiscuous
        send_frame(OTHER, 16'h0800, 64);
        status(1'b1, 1'b0, 2);
        settle();
        check("addr_drop_count", drop_count, 16'd1);
        check("addr_reason", last_reason, 3'd2);
        check("addr_no_rcv", rcv_n, 1);
        check("addr_hdr_hold", rx_eth_type, 16'h0806);
        check("promisc_good", p_good_count, 16'd2);
        check("promisc_dst", p_rx_dst_mac, 48'h001122334455);
        check("promisc_type", p_rx_eth_type, 16'h0800);

        send_frame(LOCAL, 16'h0800, 10);
        settle();
        check("runt_reason", last_reason, 3'd1);
        check("runt_drop_count", drop_count, 16'd2);

        send_frame(LOCAL, 16'h0800, 64);
        status(1'b0, 1'b1, 2);
        settle();
        check("bad_reason", last_reason, 3'd3);
        check("bad_drop_count", drop_count, 16'd3);

        send_frame(LOCAL, 16'h0800, 40);
        status(1'b1, 1'b0, 2);
        settle();
        check("len40_reason", last_reason, 3'd4);
        check("len40_drop_count", drop_count, 16'd4);
        check("len40_count_hold", rx_byte_count, 11'd60);

        send_frame(LOCAL, 16'h0800, 64);
        status(1'b1, 1'b1, 2);
        settle();
        check("goodbad_reason", last_reason, 3'd3);
        check("goodbad_drop_count", drop_count, 16'd5);

        send_frame(LOCAL, 16'h0800, 64);
        settle();
        check("timeout_reason", last_reason, 3'd5);
        check("timeout_drop_count", drop_count, 16'd6);
        check("timeout_no_rcv", rcv_n, 1);

        send_frame(LOCAL, 16'h0800, 59);
        status(1'b1, 1'b0, 2);
        settle();
        check("len59_reason", last_reason, 3'd4);
        check("len59_drop_count", drop_count, 16'd7);

        send_frame(LOCAL, 16'h88B5, 1514);
        status(1'b1, 1'b0, 2);
        settle();
        check("max_good_count", good_count, 16'd2);
        check("max_byte_count", rx_byte_count, 11'd1514);
        check("max_dst", rx_dst_mac, 48'h0012E228130E);
        check("max_type", rx_eth_type, 16'h88B5);

        send_frame(LOCAL, 16'h0800, 1515);
        status(1'b1, 1'b0, 2);
        settle();
        check("len1515_reason", last_reason, 3'd4);
        check("len1515_drop_count", drop_count, 16'd8);

        // dvld comes back while waiting for status: one NO_STATUS drop, second frame ignored
        send_frame(LOCAL, 16'h0800, 64);
        repeat (3) tick();
        send_frame(LOCAL, 16'h0800, 64);
        status(1'b1, 1'b0, 2);
        settle();
        check("reassert_reason", last_reason, 3'd5);
        check("reassert_drop_count", drop_count, 16'd9);
        check("reassert_no_rcv", rcv_n, 2);
        check("promisc_rcv_total", p_rcv_n, 3);

        // sync reset mid-frame, released with dvld still high
        rcv_before  = rcv_n;
        drop_before = drop_n;
        for (int i = 0; i < 64; i++) begin
            if (i == 20) reset = 1'b1;
            if (i == 22) reset = 1'b0;
            mac_rx_dvld = 1'b1;
            mac_rx_data = fbyte(LOCAL, 16'h0800, i);
            tick();
        end
        mac_rx_dvld = 1'b0;
        mac_rx_data = '0;
        status(1'b1, 1'b0, 2);
        settle();
        check("rstmid_no_rcv", rcv_n, rcv_before);
        check("rstmid_no_drop", drop_n, drop_before);
        check("rstmid_good_count", good_count, 16'd0);
        check("rstmid_drop_count", drop_count, 16'd0);
        check("rstmid_hdr_cleared", rx_eth_type, 16'h0000);

        send_frame(BROADCAST_MAC, ETH_TYPE_ARP, 60);
        status(1'b1, 1'b0, 2);
        settle();
        check("post_rst_good_count", good_count, 16'd1);
        check("post_rst_type", rx_eth_type, 16'h0806);
        check("post_rst_rcv", rcv_n, rcv_before + 1);
        check("never_both", both_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
